golomb_rice_decode: RTL

- Bit-serial Golomb-Rice decoder. It is the inverse of the ProRes entropy-encoder Golomb-Rice stage and recovers the unsigned values from the packed bitstream.
- Codeword format for parameter k: q zeros, then a single '1', then k remainder bits MSB-first, where q = val >> k and rem = val[k-1:0].
- The block takes 32-bit stream words MSB-first plus a per-symbol k. It outputs val and the codeword length, which is the same length the encoder reports.
- Used in the bench loopback path and in the future decoder datapath.

---
 rtl/golomb_rice_decode.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/golomb_rice_decode.sv
// Bit-serial Golomb-Rice decoder: consumes MSB-first 32-bit stream words and
// recovers (q << k) | rem plus the codeword length for each requested symbol.
module golomb_rice_decode #(
  parameter int MAX_Q = 31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        k_valid,
  input  logic [2:0]  k,
  output logic        k_ready,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_val,
  output logic [31:0] out_len,
  output logic        err
);

  localparam int QW = $clog2(MAX_Q + 1);
  localparam int VW = QW + 7;

  typedef enum logic [2:0] {IDLE, PREFIX, SUFFIX, OUT, ERR} state_t;

  state_t          state_reg;
  logic [31:0]     buf_reg;
  logic [5:0]      bitcnt_reg;
  logic [2:0]      k_reg;
  logic [2:0]      cnt_reg;
  logic [QW-1:0]   q_reg;
  logic [6:0]      rem_reg;
  logic [31:0]     out_val_reg;
  logic [31:0]     out_len_reg;
  logic            out_valid_reg;
  logic            err_reg;

  logic            bit_avail;
  logic            cur_bit;
  logic            consume;
  logic [6:0]      rem_next;
  logic [VW-1:0]   q_shift;
  logic [31:0]     len_calc;

  assign bit_avail = (bitcnt_reg != 6'd0);
  assign cur_bit   = buf_reg[31];
  assign consume   = bit_avail && (state_reg == PREFIX || state_reg == SUFFIX);
  assign rem_next  = 7'({rem_reg, cur_bit});
  assign q_shift   = VW'(q_reg) << k_reg;
  assign len_calc  = 32'(q_reg) + 32'(k_reg) + 32'd1;

  assign in_ready  = (bitcnt_reg == 6'd0) && !flush;
  assign k_ready   = (state_reg == IDLE) && !flush;
  assign out_valid = out_valid_reg;
  assign out_val   = out_val_reg;
  assign out_len   = out_len_reg;
  assign err       = err_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      buf_reg       <= '0;
      bitcnt_reg    <= '0;
      k_reg         <= '0;
      cnt_reg       <= '0;
      q_reg         <= '0;
      rem_reg       <= '0;
      out_val_reg   <= '0;
      out_len_reg   <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else if (flush) begin
      // out_val/out_len deliberately survive a flush
      state_reg     <= IDLE;
      bitcnt_reg    <= '0;
      q_reg         <= '0;
      rem_reg       <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      // Loading only happens when empty and consuming only when non-empty
      if (in_valid && in_ready) begin
        buf_reg    <= in_data;
        bitcnt_reg <= 6'd32;
      end else if (consume) begin
        buf_reg    <= {buf_reg[30:0], 1'b0};
        bitcnt_reg <= bitcnt_reg - 6'd1;
      end

      case (state_reg)
        IDLE: begin
          if (k_valid) begin
            k_reg     <= k;
            q_reg     <= '0;
            rem_reg   <= '0;
            state_reg <= PREFIX;
          end
        end
        PREFIX: begin
          if (bit_avail) begin
            if (!cur_bit) begin
              if (q_reg == QW'(MAX_Q)) begin
                state_reg <= ERR;
                err_reg   <= 1'b1;
              end else begin
                q_reg <= q_reg + QW'(1);
              end
            end else if (k_reg == 3'd0) begin
              state_reg     <= OUT;
              out_val_reg   <= 32'(q_shift);
              out_len_reg   <= len_calc;
              out_valid_reg <= 1'b1;
            end else begin
              cnt_reg   <= k_reg;
              state_reg <= SUFFIX;
            end
          end
        end
        SUFFIX: begin
          if (bit_avail) begin
            rem_reg <= rem_next;
            cnt_reg <= cnt_reg - 3'd1;
            if (cnt_reg == 3'd1) begin
              state_reg     <= OUT;
              out_val_reg   <= 32'(q_shift | VW'(rem_next));
              out_len_reg   <= len_calc;
              out_valid_reg <= 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        ERR: begin
          state_reg <= ERR;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
